// File: rtl/hs_req_tx.sv
// Source side of a four-phase req/ack crossing: holds a word, raises req,
// and walks the synchronised ack through high then low before re-arming.
module hs_req_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int SYNC_LEN       = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clock,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_req,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ack_async,
    output logic                  o_done,
    output logic                  o_timeout,
    input  logic                  i_clear_err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_HI,
        WAIT_LO,
        ERROR
    } state_t;

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] CNT_LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t                state, state_d;
    logic [SYNC_LEN-1:0]   sync;
    logic                  ack_s;
    logic [CW-1:0]         cnt, cnt_d;
    logic                  req_d, done_d, to_d;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  expired;

    // Chain resets high so a stale far-end ack cannot look like an idle line.
    always_ff @(posedge clock or posedge i_rst) begin
        if (i_rst) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_LEN-2:0], i_ack_async};
        end
    end

    assign ack_s   = sync[SYNC_LEN-1];
    assign o_ready = (state == IDLE) && !ack_s;
    assign expired = TO_EN && (cnt == CNT_LAST);

    always_ff @(posedge clock or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            o_req     <= 1'b0;
            o_data    <= '0;
            o_done    <= 1'b0;
            o_timeout <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_d;
            o_req     <= req_d;
            o_data    <= data_d;
            o_done    <= done_d;
            o_timeout <= to_d;
            cnt       <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        req_d   = o_req;
        data_d  = o_data;
        done_d  = 1'b0;
        to_d    = o_timeout;
        cnt_d   = cnt;
        unique case (state)
            IDLE: begin
                if (i_valid && o_ready) begin
                    data_d  = i_data;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                // A qualifying ack on the expiry edge still completes the phase.
                if (ack_s) begin
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = WAIT_LO;
                end else if (expired) begin
                    req_d   = 1'b0;
                    to_d    = 1'b1;
                    state_d = ERROR;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            WAIT_LO: begin
                if (!ack_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (expired) begin
                    req_d   = 1'b0;
                    to_d    = 1'b1;
                    state_d = ERROR;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            ERROR: begin
                req_d = 1'b0;
                if (i_clear_err && !ack_s) begin
                    to_d    = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_hs_req_tx.sv
// Directed and randomised checks of hs_req_tx against edge-count timing rules
// for a loopback far end, plus timeout, clear and reset scenarios.
module tb_hs_req_tx;

    localparam int DW = 8;
    localparam int SL = 3;
    localparam int TO = 16;
    // Loopback round trip: req drops SL+1 edges after accept, done after 2*(SL+1).
    localparam int T_DROP = SL + 1;
    localparam int T_DONE = 2 * (SL + 1);

    logic          clock = 1'b0;
    logic          i_rst;
    logic          i_valid;
    logic [DW-1:0] i_data;
    logic          o_ready;
    logic          o_req;
    logic [DW-1:0] o_data;
    logic          i_ack_async;
    logic          o_done;
    logic          o_timeout;
    logic          i_clear_err;

    logic loop;
    logic ack_force;

    int total  = 0;
    int passed = 0;
    int failed = 0;
    int ecount = 0;
    int ndone  = 0;

    assign i_ack_async = loop ? o_req : ack_force;

    always #5 clock = ~clock;

    hs_req_tx #(
        .DATA_WIDTH    (DW),
        .SYNC_LEN      (SL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock      (clock),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_ready    (o_ready),
        .o_req      (o_req),
        .o_data     (o_data),
        .i_ack_async(i_ack_async),
        .o_done     (o_done),
        .o_timeout  (o_timeout),
        .i_clear_err(i_clear_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        ecount++;
        @(negedge clock);
        if (o_done === 1'b1) ndone++;
    endtask

    // One loopback transfer with no competing valid; checks full timeline.
    task automatic xfer_loop(input logic [DW-1:0] w);
        loop    = 1'b1;
        i_valid = 1'b1;
        i_data  = w;
        tick();
        i_valid = 1'b0;
        i_data  = ~w;
        chk("acc_data", o_data, w);
        chk("acc_req", o_req, 1);
        for (int k = 1; k <= T_DONE + 1; k++) begin
            tick();
            chk($sformatf("lb_req_k%0d", k), o_req, k < T_DROP);
            chk($sformatf("lb_done_k%0d", k), o_done, k == T_DONE);
            chk($sformatf("lb_ready_k%0d", k), o_ready, k >= T_DONE);
            chk($sformatf("lb_data_k%0d", k), o_data, w);
        end
    endtask

    initial begin
        logic [DW-1:0] exp_data;
        int            acc_edge;
        int            next_ok;
        int            d0;
        logic          v;
        logic [DW-1:0] w;

        i_rst       = 1'b1;
        i_valid     = 1'b0;
        i_data      = '0;
        i_clear_err = 1'b0;
        loop        = 1'b0;
        ack_force   = 1'b0;

        // Reset state and re-arm delay after release
        tick();
        tick();
        chk("rst_ready", o_ready, 0);
        chk("rst_req", o_req, 0);
        chk("rst_data", o_data, 0);
        chk("rst_done", o_done, 0);
        chk("rst_timeout", o_timeout, 0);
        i_rst = 1'b0;
        for (int k = 1; k <= SL + 1; k++) begin
            tick();
            chk($sformatf("rel_ready_k%0d", k), o_ready, k >= SL);
            chk($sformatf("rel_req_k%0d", k), o_req, 0);
        end

        // Single loopback transfer
        xfer_loop(8'hA5);

        // Valid held through a busy period: second word lands after done
        ndone   = 0;
        loop    = 1'b1;
        i_valid = 1'b1;
        i_data  = 8'h11;
        tick();
        i_data = 8'h22;
        for (int k = 1; k <= T_DONE; k++) begin
            chk($sformatf("hold_data_k%0d", k), o_data, 8'h11);
            tick();
        end
        chk("hold_done1", o_done, 1);
        chk("hold_ready1", o_ready, 1);
        tick();
        i_valid = 1'b0;
        chk("hold_data2", o_data, 8'h22);
        chk("hold_req2", o_req, 1);
        for (int k = 1; k <= T_DONE; k++) tick();
        chk("hold_done2", o_done, 1);
        tick();
        chk("hold_ndone", ndone, 2);

        // Randomised offers against the edge-count model
        exp_data = 8'h22;
        acc_edge = ecount - 100;
        next_ok  = ecount + 1;
        for (int c = 0; c < 150; c++) begin
            v       = ($urandom_range(0, 2) != 0);
            w       = DW'($urandom);
            i_valid = v;
            i_data  = w;
            tick();
            if (v && ecount >= next_ok) begin
                exp_data = w;
                acc_edge = ecount;
                next_ok  = ecount + T_DONE + 1;
            end
            d0 = ecount - acc_edge;
            chk($sformatf("rnd_data_c%0d", c), o_data, exp_data);
            chk($sformatf("rnd_req_c%0d", c), o_req, d0 < T_DROP);
            chk($sformatf("rnd_done_c%0d", c), o_done, d0 == T_DONE);
            chk($sformatf("rnd_ready_c%0d", c), o_ready, d0 >= T_DONE);
        end
        i_valid = 1'b0;
        for (int k = 0; k < T_DONE + 2; k++) tick();
        chk("rnd_idle_ready", o_ready, 1);

        // Dead far end: timeout, then clear
        loop      = 1'b0;
        ack_force = 1'b0;
        ndone     = 0;
        i_valid   = 1'b1;
        i_data    = 8'h5A;
        tick();
        i_valid = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            tick();
            chk($sformatf("to_req_k%0d", k), o_req, k < TO);
            chk($sformatf("to_flag_k%0d", k), o_timeout, k >= TO);
        end
        chk("to_ready", o_ready, 0);
        tick();
        chk("to_sticky", o_timeout, 1);
        i_clear_err = 1'b1;
        tick();
        i_clear_err = 1'b0;
        chk("clr_timeout", o_timeout, 0);
        chk("clr_ready", o_ready, 1);
        chk("clr_ndone", ndone, 0);
        chk("clr_data", o_data, 8'h5A);
        i_clear_err = 1'b1;
        tick();
        i_clear_err = 1'b0;
        chk("idle_clr_ready", o_ready, 1);
        chk("idle_clr_req", o_req, 0);
        chk("idle_clr_timeout", o_timeout, 0);

        // Ack held high across reset release
        ack_force = 1'b1;
        i_rst     = 1'b1;
        tick();
        i_rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("ackhi_ready_k%0d", k), o_ready, 0);
        end
        ack_force = 1'b0;
        for (int k = 1; k <= SL; k++) begin
            tick();
            chk($sformatf("acklo_ready_k%0d", k), o_ready, k >= SL);
        end
        chk("ackhi_ndone", ndone, 0);

        // Reset mid-WAIT_HI, far end still acking, then recovery
        i_valid = 1'b1;
        i_data  = 8'h77;
        tick();
        i_valid = 1'b0;
        tick();
        chk("mid_req", o_req, 1);
        ack_force = 1'b1;
        #2 i_rst = 1'b1;
        #1;
        chk("mid_rst_req", o_req, 0);
        chk("mid_rst_data", o_data, 0);
        chk("mid_rst_ready", o_ready, 0);
        @(negedge clock);
        i_rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 4; k++) tick();
        chk("mid_hold_ready", o_ready, 0);
        ack_force = 1'b0;
        for (int k = 0; k < SL; k++) tick();
        chk("mid_rearm_ready", o_ready, 1);
        chk("mid_ndone", ndone, 0);
        xfer_loop(8'h3C);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
